// File: rtl/column_hit_judge.sv
// Per-column hit judge: turns key press edges and the bottom-row light into HIT/MISS pulses plus score/combo.
// Optional macro COMBO_BONUS_EN: hits score 2 once the pre-hit combo reaches BONUS_THRESH.
module column_hit_judge #(
  parameter int SCORE_MAX    = 999,
  parameter int COMBO_MAX    = 99,
  parameter int BONUS_THRESH = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bottomlight_i,
  input  logic       key_i,
  output logic       hit_o,
  output logic       miss_o,
  output logic [9:0] score_o,
  output logic [6:0] combo_o
);

  // state  | meaning
  // IDLE   | no note in the hit zone
  // ARMED  | note present, not yet judged
  // JUDGED | note hit, waiting for it to leave the zone
  typedef enum logic [1:0] {IDLE, ARMED, JUDGED} state_t;

`ifdef COMBO_BONUS_EN
  localparam logic BONUS_EN = 1'b1;
`else
  localparam logic BONUS_EN = 1'b0;
`endif

  localparam logic [9:0] SCORE_CAP = 10'(SCORE_MAX);
  localparam logic [6:0] COMBO_CAP = 7'(COMBO_MAX);
  localparam logic [7:0] BONUS_LVL = 8'(BONUS_THRESH);

  state_t      state_q, state_d;
  logic        key_q;
  logic        hit_q, hit_d;
  logic        miss_q, miss_d;
  logic [9:0]  score_q, score_d;
  logic [6:0]  combo_q, combo_d;
  logic        press;
  logic [10:0] inc;
  logic [10:0] score_sum;
  logic [7:0]  combo_sum;

  assign press = key_i & ~key_q;

  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bottomlight_i && press) begin
          state_d = JUDGED;
          hit_d   = 1'b1;
        end else if (bottomlight_i) begin
          state_d = ARMED;
        end else if (press) begin
          miss_d  = 1'b1;
        end
      end
      ARMED: begin
        // a press on the same cycle the light drops still counts as a hit
        if (press) begin
          state_d = JUDGED;
          hit_d   = 1'b1;
        end else if (!bottomlight_i) begin
          state_d = IDLE;
          miss_d  = 1'b1;
        end
      end
      JUDGED: begin
        if (!bottomlight_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // sums are one bit wider than the registers so clamping sees any overflow
  always_comb begin
    inc       = (BONUS_EN && ({1'b0, combo_q} >= BONUS_LVL)) ? 11'd2 : 11'd1;
    score_sum = {1'b0, score_q} + inc;
    combo_sum = {1'b0, combo_q} + 8'd1;
    score_d   = score_q;
    combo_d   = combo_q;
    if (hit_d) begin
      score_d = (score_sum > {1'b0, SCORE_CAP}) ? SCORE_CAP : score_sum[9:0];
      combo_d = (combo_sum > {1'b0, COMBO_CAP}) ? COMBO_CAP : combo_sum[6:0];
    end else if (miss_d) begin
      combo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      score_q <= '0;
      combo_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_i;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      score_q <= score_d;
      combo_q <= combo_d;
    end
  end

  assign hit_o   = hit_q;
  assign miss_o  = miss_q;
  assign score_o = score_q;
  assign combo_o = combo_q;

endmodule
